// File: rtl/mac_issue_queue.sv
// mac_issue_queue: issues operand triples to a fixed-latency MAC, tracks them
// in a valid/tag shadow pipe and collects results in a credit-guarded FIFO.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake (in_a/b/c, in_op, in_tag)
//   mac_a/b/c, mac_op        registered operands to the MAC
//   mac_y                    MAC result, sampled MAC_LATENCY edges after issue
//   out_valid/out_ready      result handshake (out_y, out_tag), FWFT head
//   busy                     any op in flight or buffered
module mac_issue_queue #(
  parameter int MAC_LATENCY = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [31:0]      in_c,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  output logic [31:0]      mac_c,
  output logic             mac_op,
  input  logic [31:0]      mac_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // credits: in-flight ops plus buffered results
  logic [CW-1:0] used;

  logic issue;
  logic push;
  logic pop;
  logic empty;
  logic full;

  logic [MAC_LATENCY-1:0] vld_pipe;
  logic [TAG_W-1:0]       tag_pipe [MAC_LATENCY];

  logic [31:0]      mem_y   [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  // in_ready looks only at registered state, never at in_valid
  assign in_ready = !rst && (used < DEPTH_C);
  assign issue    = in_valid && in_ready;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_idx == rd_idx) &&
                 (wr_ptr[AW] != rd_ptr[AW]);

  assign push = vld_pipe[MAC_LATENCY-1] && !rst;
  assign pop  = out_valid && out_ready;

  assign out_valid = !empty;
  assign busy      = (used != '0);

  // head is forced to zero when nothing is buffered
  assign out_y   = out_valid ? mem_y[rd_idx]   : '0;
  assign out_tag = out_valid ? mem_tag[rd_idx] : '0;

  // operand registers: hold when nothing issues
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_a  <= '0;
      mac_b  <= '0;
      mac_c  <= '0;
      mac_op <= 1'b0;
    end else if (issue) begin
      mac_a  <= in_a;
      mac_b  <= in_b;
      mac_c  <= in_c;
      mac_op <= in_op;
    end
  end

  // shadow pipe shifts every cycle; the MAC never stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < MAC_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= issue;
      tag_pipe[0] <= issue ? in_tag : '0;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // result storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wr_idx]   <= mac_y;
      mem_tag[wr_idx] <= tag_pipe[MAC_LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // a pop frees its credit only for the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      used <= '0;
    end else begin
      unique case ({issue, pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full))
        else $error("result pushed into full FIFO");
      assert (used <= DEPTH_C)
        else $error("credit counter overflow");
    end
  end

endmodule

// File: tb/tb_mac_issue_queue.sv
// tb_mac_issue_queue: randomized and directed stimulus for mac_issue_queue,
// checked each cycle against a queue-based model of accepted operations.
module tb_mac_issue_queue;

  localparam int L     = 4;
  localparam int DEPTH = 8;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_a = '0;
  logic [31:0]   in_b = '0;
  logic [31:0]   in_c = '0;
  logic          in_op = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic [31:0]   mac_a;
  logic [31:0]   mac_b;
  logic [31:0]   mac_c;
  logic          mac_op;
  logic [31:0]   mac_y;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_y;
  logic [TW-1:0] out_tag;
  logic          busy;

  always #5 clk = ~clk;

  mac_issue_queue #(
    .MAC_LATENCY(L),
    .FIFO_DEPTH(DEPTH),
    .TAG_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_c(in_c),
    .in_op(in_op),
    .in_tag(in_tag),
    .mac_a(mac_a),
    .mac_b(mac_b),
    .mac_c(mac_c),
    .mac_op(mac_op),
    .mac_y(mac_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y(out_y),
    .out_tag(out_tag),
    .busy(busy)
  );

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real r;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    while (e > 127) begin r = r * 2.0; e--; end
    while (e < 127) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    real         a;
    int          e;
    longint      m;
    logic        s;
    logic [7:0]  eb;
    logic [22:0] mb;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m  = longint'((a - 1.0) * 8388608.0);
    eb = e[7:0];
    mb = m[22:0];
    return {s, eb, mb};
  endfunction

  function automatic logic [31:0] fmac(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c,
                                       input logic op);
    real p;
    p = f2r(a) * f2r(b);
    return r2f(op ? p - f2r(c) : p + f2r(c));
  endfunction

  function automatic logic [31:0] rnd_op();
    int v;
    v = int'($urandom_range(16)) - 8;
    return r2f(real'(v));
  endfunction

  // behavioural MAC: L-1 register stages behind the operand registers
  logic [31:0] ms [L-1];
  always @(posedge clk) begin
    ms[0] <= fmac(mac_a, mac_b, mac_c, mac_op);
    for (int i = 1; i < L-1; i++) ms[i] <= ms[i-1];
  end
  assign mac_y = ms[L-2];

  typedef struct {
    logic [31:0]   y;
    logic [TW-1:0] tag;
    int            rdy;
  } ent_t;

  ent_t          q[$];
  logic [31:0]   pop_y[$];
  logic [TW-1:0] pop_tag[$];
  int            pop_edge[$];

  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   edge_n = 0;
  int   acc_edge = 0;
  int   n_acc = 0;
  bit   chk_en = 1'b0;
  bit   done = 1'b0;
  logic [31:0] ea = '0;
  logic [31:0] eb = '0;
  logic [31:0] ec = '0;
  logic        eop = 1'b0;

  logic [31:0] va [8] = '{32'h41700000, 32'h41700000, 32'h40000000,
                          32'h40000000, 32'h40400000, 32'h40400000,
                          32'h40800000, 32'h40800000};
  logic [31:0] vb [8] = '{32'h3f800000, 32'h3f800000, 32'h3f000000,
                          32'h3f000000, 32'h40400000, 32'h40400000,
                          32'h3e800000, 32'h3e800000};
  logic [31:0] vc [8] = '{32'h40000000, 32'h40000000, 32'h3f800000,
                          32'h3f800000, 32'h3f800000, 32'h3f800000,
                          32'h40a00000, 32'h40a00000};
  logic [31:0] vy [8] = '{32'h41880000, 32'h41500000, 32'h40000000,
                          32'h00000000, 32'h41200000, 32'h41000000,
                          32'h40c00000, 32'hc0800000};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  // model holds the state after the latest edge; updated for the next one
  always @(negedge clk) begin
    bit er;
    bit eo;
    bit acc;
    bit pop;
    er = !rst && (q.size() < DEPTH);
    eo = (q.size() > 0) && (q[0].rdy <= cyc);
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(er));
      chk("out_valid", 64'(out_valid), 64'(eo));
      chk("busy", 64'(busy), 64'(q.size() != 0));
      chk("mac_a", 64'(mac_a), 64'(ea));
      chk("mac_bc", {mac_b, mac_c}, {eb, ec});
      chk("mac_op", 64'(mac_op), 64'(eop));
      if (eo) begin
        chk("out_y", 64'(out_y), 64'(q[0].y));
        chk("out_tag", 64'(out_tag), 64'(q[0].tag));
      end
    end
    acc = in_valid && er;
    pop = eo && out_ready;
    if (rst) begin
      q.delete();
      ea = '0; eb = '0; ec = '0; eop = 1'b0;
    end else begin
      if (pop) begin
        pop_y.push_back(out_y);
        pop_tag.push_back(out_tag);
        pop_edge.push_back(edge_n + 1);
        q.delete(0);
      end
      if (acc) begin
        q.push_back('{y: fmac(in_a, in_b, in_c, in_op),
                      tag: in_tag, rdy: cyc + 1 + L});
        ea = in_a; eb = in_b; ec = in_c; eop = in_op;
        acc_edge = edge_n + 1;
        n_acc++;
      end
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic op,
                      input logic [TW-1:0] tag, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    in_a = a; in_b = b; in_c = c; in_op = op; in_tag = tag;
    in_valid = 1'b1;
    while (!got && waited < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (!got) waited++;
    end
    in_valid = 1'b0;
    if (!got) chk("send_timeout", 64'(got), 64'(1));
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (busy && t < budget) begin
      tick(1);
      t++;
    end
    chk("drain", 64'(busy), 64'(0));
  endtask

  task automatic pop_clear();
    pop_y.delete();
    pop_tag.delete();
    pop_edge.delete();
  endtask

  // hold in_valid with fresh random operands for n cycles, count accepts
  task automatic stream(input int n, output int accepted);
    accepted = 0;
    for (int i = 0; i < n; i++) begin
      in_a = rnd_op(); in_b = rnd_op(); in_c = rnd_op();
      in_op = 1'($urandom_range(1));
      in_tag = TW'(accepted);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) accepted++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int w;
    int ab;
    int n;
    int stalls;
    int n0;

    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_mac", {mac_a, mac_b ^ mac_c}, 64'(0));
    chk("rst_out", {out_y, 28'(0), out_tag}, 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    chk("model_add", 64'(fmac(32'h41c80000, 32'h40000000,
                              32'h40000000, 1'b0)), 64'(32'h42500000));
    chk("model_sub", 64'(fmac(32'h41c80000, 32'h40000000,
                              32'h40000000, 1'b1)), 64'(32'h42400000));
    chk("model_17", 64'(fmac(va[0], vb[0], vc[0], 1'b0)), 64'(vy[0]));
    chk("model_0", 64'(fmac(va[3], vb[3], vc[3], 1'b1)), 64'(vy[3]));
    chk("model_neg", 64'(fmac(va[7], vb[7], vc[7], 1'b1)), 64'(vy[7]));

    // single op, both signs
    tick(1);
    out_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      pop_clear();
      send(32'h41c80000, 32'h40000000, 32'h40000000, 1'(s),
           TW'(5 + s), w);
      ab = acc_edge;
      wait_idle(20);
      chk("single_cnt", 64'(pop_y.size()), 64'(1));
      if (pop_y.size() == 1) begin
        chk("single_y", 64'(pop_y[0]),
            64'(s == 0 ? 32'h42500000 : 32'h42400000));
        chk("single_tag", 64'(pop_tag[0]), 64'(5 + s));
        chk("single_lat", 64'(pop_edge[0] - ab), 64'(L + 1));
      end
    end

    // back-to-back
    pop_clear();
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      send(va[i], vb[i], vc[i], 1'(i % 2), TW'(i), w);
      stalls += w;
    end
    chk("b2b_stalls", 64'(stalls), 64'(0));
    wait_idle(30);
    chk("b2b_cnt", 64'(pop_y.size()), 64'(8));
    if (pop_y.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("b2b_y", 64'(pop_y[i]), 64'(vy[i]));
        chk("b2b_tag", 64'(pop_tag[i]), 64'(i));
        chk("b2b_edge", 64'(pop_edge[i] - pop_edge[0]), 64'(i));
      end
    end

    // backpressure
    out_ready = 1'b0;
    pop_clear();
    stream(20, n);
    chk("bp_accepts", 64'(n), 64'(DEPTH));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_pre", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_ready_post", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    wait_idle(40);
    chk("bp_cnt", 64'(pop_y.size()), 64'(DEPTH));
    if (pop_y.size() == DEPTH) begin
      for (int i = 0; i < DEPTH; i++) begin
        chk("bp_tag", 64'(pop_tag[i]), 64'(i));
      end
    end

    // credit at the boundary
    out_ready = 1'b0;
    stream(12, n);
    tick(L + 1);
    chk("cb_full", 64'(in_ready), 64'(0));
    pop_clear();
    n0 = n_acc;
    in_a = va[4]; in_b = vb[4]; in_c = vc[4]; in_op = 1'b0;
    in_tag = TW'(10);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("cb_ready0", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("cb_ready1", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("cb_ready2", 64'(in_ready), 64'(0));
    chk("cb_pops", 64'(pop_y.size()), 64'(1));
    chk("cb_accepts", 64'(n_acc - n0), 64'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle(60);

    // reset with ops in flight
    pop_clear();
    for (int i = 0; i < 3; i++) begin
      send(va[i], vb[i], vc[i], 1'b0, TW'(i), w);
    end
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_mac", {mac_a, 31'(0), mac_op}, 64'(0));
    chk("mrst_in_ready", 64'(in_ready), 64'(1));
    tick(10);
    chk("mrst_nopop", 64'(pop_y.size()), 64'(0));
    send(va[4], vb[4], vc[4], 1'b0, TW'(9), w);
    wait_idle(20);
    chk("mrst_cnt", 64'(pop_y.size()), 64'(1));
    if (pop_y.size() == 1) begin
      chk("mrst_y", 64'(pop_y[0]), 64'(32'h41200000));
      chk("mrst_tag", 64'(pop_tag[0]), 64'(9));
    end

    // random traffic
    pop_clear();
    n0 = n_acc;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1200; i++) begin
          tick(int'($urandom_range(2)));
          send(rnd_op(), rnd_op(), rnd_op(), 1'($urandom_range(1)),
               TW'($urandom), w);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(1));
          tick(1);
        end
      end
    join
    out_ready = 1'b1;
    wait_idle(100);
    chk("rnd_acc", 64'(n_acc - n0), 64'(1200));
    chk("rnd_pops", 64'(pop_y.size()), 64'(1200));

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mac_issue_queue.md
# mac_issue_queue

Streaming front-end and result collector for the pipelined floating-point `mac` unit (Y = A*B ± C, fixed latency, no stall input). It accepts operand triples over a valid/ready handshake and issues at most one per cycle to the MAC. It tracks in-flight operations with a valid/tag shadow pipeline and captures each result into an output FIFO. Credit accounting guarantees that no result leaving the MAC is ever dropped, even under downstream backpressure.

## Interface
Parameters:
- MAC_LATENCY, 4, cycles from the issue edge to the edge at which the matching `mac_y` is sampled (≥1)
- FIFO_DEPTH, 4, result FIFO entries, power of 2, ≥2
- TAG_W, 4, width of the user tag carried alongside each operation

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand triple presented
- in_ready  out  1  triple accepted this cycle when in_valid & in_ready
- in_a, in_b, in_c  in  32 each  IEEE-754 single operands
- in_op  in  1  0: A*B+C, 1: A*B−C
- in_tag  in  TAG_W  user tag, returned with result
- mac_a, mac_b, mac_c  out  32 each  registered operands to MAC
- mac_op  out  1  registered op to MAC
- mac_y  in  32  MAC result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_y  out  32  result (FIFO head, first-word-fall-through)
- out_tag  out  TAG_W  tag of out_y
- busy  out  1  any op in flight or buffered

## Operation
- Issue: on edge with in_valid & in_ready, register in_a/b/c/op onto mac_*. Set vld_pipe[0]=1 and tag_pipe[0]=in_tag. Otherwise mac_* hold their previous values and vld_pipe[0]=0.
- Shadow pipeline: vld_pipe/tag_pipe are MAC_LATENCY stages and shift every cycle unconditionally. The MAC cannot stall.
- Capture: on any edge where vld_pipe[MAC_LATENCY-1]=1, push {mac_y, tag_pipe[MAC_LATENCY-1]} into the FIFO.
- Pop: on an edge with out_valid & out_ready, advance the FIFO head.
- Credits: counter `used` (0..FIFO_DEPTH) = in-flight ops + FIFO occupancy.
  - +1 on issue, −1 on pop, unchanged when both or neither occur.
- in_ready = !rst & (used < FIFO_DEPTH), combinational from registered state only. It must not depend on in_valid.
- Because of credits, the FIFO is never pushed while full. An assertion must flag a push-while-full.
- Ordering: results leave strictly in issue order. Tags are never reordered.
- out_valid = FIFO non-empty. out_y/out_tag are valid only when out_valid.
- busy = (used != 0).
- Reset (any cycle, including mid-flight):
  - used=0, vld_pipe=0, tag_pipe=0, FIFO empty.
  - mac_a/b/c=0, mac_op=0.
  - out_valid=0, out_y=0, out_tag=0, busy=0.
- Results emerging from the MAC after reset are discarded, because vld_pipe is cleared.
- No arithmetic is done here. Values pass bit-exact from in_* to mac_* and from mac_y to out_y.

## Timing
- Issue at edge k: mac_* change at edge k; result pushed at edge k+MAC_LATENCY; out_valid high after that edge if the FIFO was empty (total in→out latency MAC_LATENCY+1 cycles to first acceptable out).
- Throughput: 1 op/cycle sustained while out_ready=1 and FIFO_DEPTH ≥ MAC_LATENCY+1. Smaller depth throttles to FIFO_DEPTH ops per MAC_LATENCY+1 cycles. This is required behaviour.
- used==FIFO_DEPTH: in_ready=0. A pop at the same edge frees a credit, and in_ready rises the following cycle, not the same cycle.
- Simultaneous push and pop, FIFO full: cannot occur (credits). FIFO empty: pushed entry becomes head; out_valid rises after the edge.
- Pointer wrap: FIFO pointers are log2(FIFO_DEPTH)+1 bits; full/empty is derived from the MSB difference.

## Test plan
- Single op: A=41c80000, B=40000000, C=40000000, op=0; behavioural MAC model of latency 4 → out_y=42500000 (52.0) with the issue tag, out_valid exactly 5 cycles after accept; op=1 → 42400000 (48.0).
- Back-to-back: 8 ops (15*1±2, 2*0.5±1, …), tags 0..7, out_ready=1, FIFO_DEPTH=8 → in_ready stays 1, results 41880000, 41500000, 40000000, 00000000, … in tag order, one per cycle.
- Backpressure: out_ready=0, stream ops → in_ready drops after exactly FIFO_DEPTH accepts; no push-while-full; raise out_ready → all FIFO_DEPTH results drain in order, in_ready reasserts one cycle after the first pop.
- Credit at boundary: used==FIFO_DEPTH, out_ready pulsed one cycle with in_valid=1 → exactly one pop, then one accept on the next cycle; used returns to FIFO_DEPTH.
- Reset mid-flight: 3 ops issued, rst high at edge 2 after the last issue → out_valid never rises for those ops, busy=0, used=0, mac_*=0 after the reset edge; a new op after reset completes normally with the correct tag.
- Tag integrity under random in_valid/out_ready (≥1000 ops, scoreboard) → every result matches the model and its tag, zero drops, zero duplicates.
